// File: rtl/branch_control.sv
// PC redirect/flush/startup sequencer: registered outputs, redirect one cycle after acceptance; stall holds decode while waiting for zero_flag.
// Optional BRANCH_STATS_EN adds saturating taken_count/stall_count outputs.
`timescale 1ns/1ps
module branch_control #(
   parameter int STARTUP_CYCLES = 2,
   parameter int PIPE_DEPTH     = 1
) (
   input  logic       clk,
   input  logic       startup_n,
   input  logic       br_valid,
   input  logic [1:0] br_type,
   input  logic [7:0] br_offset,
   input  logic       flag_valid,
   input  logic       zero_flag,
   output logic       startup,
   output logic [7:0] pc_control,
   output logic [7:0] jump_offset,
   output logic       flush,
   output logic       stall
`ifdef BRANCH_STATS_EN
   ,
   output logic [15:0] taken_count,
   output logic [15:0] stall_count
`endif
);

   typedef enum logic [2:0] {HOLD, RUN, WAIT_FLAG, REDIRECT, FLUSH} state_t;

   localparam logic [3:0] SU_LAST = 4'(STARTUP_CYCLES - 1);
   localparam logic [3:0] FL_LAST = 4'((PIPE_DEPTH > 1) ? (PIPE_DEPTH - 2) : 0);
   localparam logic [7:0] PD8     = 8'(PIPE_DEPTH);

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       lat_ne_q, lat_ne_d;
   logic [7:0] lat_off_q, lat_off_d;
   logic       startup_q, startup_d;
   logic [7:0] pc_q, pc_d;
   logic [7:0] jo_q, jo_d;
   logic       flush_q, flush_d;
   logic       stall_q, stall_d;
   logic       fire;
   logic [7:0] fire_off;

   // ne selects branch-if-not-zero (type 11) versus branch-if-zero (type 10)
   function automatic logic cond_taken(input logic ne, input logic z);
      return ne ? !z : z;
   endfunction

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      lat_ne_d  = lat_ne_q;
      lat_off_d = lat_off_q;
      fire      = 1'b0;
      fire_off  = br_offset;
      case (state_q)
         HOLD: begin
            if (cnt_q == SU_LAST) begin
               state_d = RUN;
               cnt_d   = 4'd0;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         RUN: begin
            if (br_valid) begin
               case (br_type)
                  2'b01: fire = 1'b1;
                  2'b10, 2'b11: begin
                     if (flag_valid) begin
                        fire = cond_taken(br_type[0], zero_flag);
                     end else begin
                        state_d   = WAIT_FLAG;
                        lat_ne_d  = br_type[0];
                        lat_off_d = br_offset;
                     end
                  end
                  default: ;
               endcase
            end
         end
         WAIT_FLAG: begin
            fire_off = lat_off_q;
            if (flag_valid) begin
               if (cond_taken(lat_ne_q, zero_flag)) fire = 1'b1;
               else state_d = RUN;
            end
         end
         REDIRECT: begin
            state_d = (PIPE_DEPTH > 1) ? FLUSH : RUN;
            cnt_d   = 4'd0;
         end
         FLUSH: begin
            if (cnt_q == FL_LAST) begin
               state_d = RUN;
               cnt_d   = 4'd0;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         default: state_d = HOLD;
      endcase
      if (fire) state_d = REDIRECT;

      // Outputs are registered from the next state so they line up with it
      startup_d = (state_d == HOLD);
      pc_d      = (state_d == REDIRECT) ? 8'hFF : 8'h00;
      jo_d      = fire ? (fire_off - PD8) : 8'h00;
      flush_d   = (state_d == REDIRECT) || (state_d == FLUSH);
      stall_d   = (state_d == WAIT_FLAG);
   end

   always_ff @(posedge clk or negedge startup_n) begin
      if (!startup_n) begin
         state_q   <= HOLD;
         cnt_q     <= 4'd0;
         lat_ne_q  <= 1'b0;
         lat_off_q <= 8'h00;
         startup_q <= 1'b1;
         pc_q      <= 8'h00;
         jo_q      <= 8'h00;
         flush_q   <= 1'b0;
         stall_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         lat_ne_q  <= lat_ne_d;
         lat_off_q <= lat_off_d;
         startup_q <= startup_d;
         pc_q      <= pc_d;
         jo_q      <= jo_d;
         flush_q   <= flush_d;
         stall_q   <= stall_d;
      end
   end

   assign startup     = startup_q;
   assign pc_control  = pc_q;
   assign jump_offset = jo_q;
   assign flush       = flush_q;
   assign stall       = stall_q;

`ifdef BRANCH_STATS_EN
   logic [15:0] taken_cnt_q, taken_cnt_d;
   logic [15:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      taken_cnt_d = taken_cnt_q;
      stall_cnt_d = stall_cnt_q;
      if (fire && (taken_cnt_q != 16'hFFFF)) taken_cnt_d = taken_cnt_q + 16'd1;
      if ((state_q == WAIT_FLAG) && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
   end

   always_ff @(posedge clk or negedge startup_n) begin
      if (!startup_n) begin
         taken_cnt_q <= 16'd0;
         stall_cnt_q <= 16'd0;
      end else begin
         taken_cnt_q <= taken_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign taken_count = taken_cnt_q;
   assign stall_count = stall_cnt_q;
`endif

endmodule
